// File: rtl/speed_governor_pkg.sv
// rtl/speed_governor_pkg.sv - shared types and constants for the speed governor
//
// Purpose: state encoding, per-gear speed bands and key-off braking steps.
// Gear tables are indexed directly by the 3-bit gear input. Entries that
// mean "up to the absolute ceiling" hold GEAR_FULL, and gear_max() clips
// them to the instance's MAX_SPEED.
package speed_governor_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_STALL = 2'd3
  } state_t;

  localparam int GEAR_FULL = 32'h7fff_ffff;

  //                              N   g1  g2  g3  g4  g5         g6         N
  localparam int GEAR_MIN [8] = '{0,  0,  15, 35, 55, 75,        0,         0};
  localparam int GEAR_MAX [8] = '{GEAR_FULL, 25, 45, 65, 85, GEAR_FULL, GEAR_FULL, GEAR_FULL};

  // Key-off stepped braking: above HI drop by STEP_HI, above LO by STEP_MID,
  // otherwise by STEP_LO until standstill.
  localparam int KOFF_THR_HI   = 10;
  localparam int KOFF_THR_LO   = 5;
  localparam int KOFF_STEP_HI  = 10;
  localparam int KOFF_STEP_MID = 5;
  localparam int KOFF_STEP_LO  = 1;

  function automatic logic is_neutral(input logic [2:0] g);
    return (g == 3'd0) || (g == 3'd7);
  endfunction

  function automatic int gear_max(input logic [2:0] g, input int ceiling);
    return (GEAR_MAX[g] < ceiling) ? GEAR_MAX[g] : ceiling;
  endfunction

endpackage

// File: rtl/speed_governor_tick_prescaler.sv
// rtl/speed_governor_tick_prescaler.sv - single-cycle update tick generator
//
// Purpose: divides clk by DIV; tick is high for one cycle when the count
// reaches DIV-1, so the first tick arrives DIV cycles after rst drops.
// Ports: clk, rst (sync, active-high), tick (out, 1 cycle every DIV clocks).
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/speed_governor.sv
// rtl/speed_governor.sv - tick-driven vehicle speed governor
//
// Purpose: integrates accel/brake into a saturating speed register with
// gear-dependent bands, coasting decay, over-speed bleed-off after a
// downshift, stall detection and key-off stepped braking.
// Ports: clk, rst (sync, active-high), key_on, accel, brake (wins over
// accel), gear[2:0]; speed[SPEED_W-1:0], state[1:0] (OFF/IDLE/DRIVE/STALL),
// overspeed (speed above gear max), lugging (below gear min while driving).
module speed_governor
  import speed_governor_pkg::*;
#(
  parameter int SPEED_W     = 7,
  parameter int MAX_SPEED   = 99,
  parameter int TICK_DIV    = 4,
  parameter int COAST_DIV   = 8,
  parameter int STALL_TICKS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_on,
  input  logic               accel,
  input  logic               brake,
  input  logic [2:0]         gear,
  output logic [SPEED_W-1:0] speed,
  output logic [1:0]         state,
  output logic               overspeed,
  output logic               lugging
);

  localparam int CCW = $clog2(COAST_DIV + 1);
  localparam int LCW = $clog2(STALL_TICKS + 1);
  localparam logic [CCW-1:0] COAST_LAST = CCW'(COAST_DIV - 1);
  localparam logic [LCW-1:0] LUG_LAST   = LCW'(STALL_TICKS - 1);

  typedef logic [SPEED_W-1:0] spd_t;

  logic           tick;
  state_t         st;
  logic [CCW-1:0] coast_cnt;
  logic [LCW-1:0] lug_cnt;
  spd_t           gmin;
  spd_t           gmax;
  logic           neutral;

  tick_prescaler #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign gmin      = spd_t'(GEAR_MIN[gear]);
  assign gmax      = spd_t'(gear_max(gear, MAX_SPEED));
  assign neutral   = is_neutral(gear);
  assign overspeed = (speed > gmax);
  assign lugging   = (st == ST_DRIVE) && (speed < gmin);
  assign state     = st;

  // A speed already at or below the floor holds; the floor never pulls
  // speed upward (matters while lugging below the gear minimum).
  function automatic spd_t dec_floor(input spd_t s, input spd_t fl);
    return (s > fl) ? s - spd_t'(1) : s;
  endfunction

  function automatic spd_t key_off_step(input spd_t s);
    if (s > spd_t'(KOFF_THR_HI)) return s - spd_t'(KOFF_STEP_HI);
    if (s > spd_t'(KOFF_THR_LO)) return s - spd_t'(KOFF_STEP_MID);
    if (s > spd_t'(0))           return s - spd_t'(KOFF_STEP_LO);
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_OFF;
      speed     <= '0;
      coast_cnt <= '0;
      lug_cnt   <= '0;
    end else if (tick) begin
      if (!key_on) begin
        // Key-off overrides any gear change on the same tick.
        st        <= ST_OFF;
        coast_cnt <= '0;
        lug_cnt   <= '0;
        if (brake) speed <= key_off_step(speed);
      end else begin
        case (st)
          ST_OFF: begin
            st        <= ST_IDLE;
            coast_cnt <= '0;
            lug_cnt   <= '0;
          end

          ST_IDLE: begin
            lug_cnt <= '0;
            if (!neutral) begin
              st        <= ST_DRIVE;
              coast_cnt <= '0;
            end else if (brake) begin
              speed     <= dec_floor(speed, '0);
              coast_cnt <= '0;
            end else if (accel) begin
              coast_cnt <= '0;
            end else if (coast_cnt == COAST_LAST) begin
              speed     <= dec_floor(speed, '0);
              coast_cnt <= '0;
            end else begin
              coast_cnt <= coast_cnt + 1'b1;
            end
          end

          ST_DRIVE: begin
            if (neutral) begin
              st        <= ST_IDLE;
              coast_cnt <= '0;
              lug_cnt   <= '0;
            end else begin
              if (overspeed) begin
                speed     <= speed - spd_t'(1);
                coast_cnt <= '0;
              end else if (brake) begin
                speed     <= dec_floor(speed, lugging ? spd_t'(0) : gmin);
                coast_cnt <= '0;
              end else if (accel) begin
                if (speed < gmax) speed <= speed + spd_t'(1);
                coast_cnt <= '0;
              end else if (coast_cnt == COAST_LAST) begin
                speed     <= dec_floor(speed, gmin);
                coast_cnt <= '0;
              end else begin
                coast_cnt <= coast_cnt + 1'b1;
              end

              // Placed after the speed rules so the stall transition's
              // coast clear takes precedence.
              if (lugging && !accel) begin
                if (lug_cnt == LUG_LAST) begin
                  st        <= ST_STALL;
                  lug_cnt   <= '0;
                  coast_cnt <= '0;
                end else begin
                  lug_cnt <= lug_cnt + 1'b1;
                end
              end else begin
                lug_cnt <= '0;
              end
            end
          end

          ST_STALL: begin
            lug_cnt <= '0;
            if (neutral) begin
              st        <= ST_IDLE;
              coast_cnt <= '0;
            end else if (brake) begin
              speed     <= dec_floor(speed, '0);
              coast_cnt <= '0;
            end else if (accel) begin
              coast_cnt <= '0;
            end else if (coast_cnt == COAST_LAST) begin
              speed     <= dec_floor(speed, '0);
              coast_cnt <= '0;
            end else begin
              coast_cnt <= coast_cnt + 1'b1;
            end
          end

          default: st <= ST_OFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_speed_governor.sv
// tb/tb_speed_governor.sv - directed scoreboard bench for speed_governor
module tb_speed_governor;
  import speed_governor_pkg::*;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_on = 1'b0;
  logic       accel = 1'b0;
  logic       brake = 1'b0;
  logic [2:0] gear = 3'd0;
  logic [6:0] speed;
  logic [1:0] state;
  logic       overspeed;
  logic       lugging;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [6:0] spd;
    logic [1:0] st;
  } exp_t;

  exp_t sb [$];

  speed_governor #(
    .SPEED_W(7), .MAX_SPEED(99), .TICK_DIV(TICK_DIV),
    .COAST_DIV(8), .STALL_TICKS(16)
  ) dut (
    .clk(clk), .rst(rst), .key_on(key_on), .accel(accel), .brake(brake),
    .gear(gear), .speed(speed), .state(state),
    .overspeed(overspeed), .lugging(lugging)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] exp);
    checks++;
    assert (state === exp) else begin
      errors++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, state, exp);
    end
  endtask

  // Queue the expected result, advance one update tick, then compare.
  task automatic tick_exp(input int spd, input logic [1:0] st, input string tag);
    exp_t e;
    e.tag = tag;
    e.spd = 7'(spd);
    e.st  = st;
    sb.push_back(e);
    repeat (TICK_DIV) @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (speed === e.spd) else begin
      errors++;
      $error("FAIL %s speed observed=%0d expected=%0d", e.tag, speed, e.spd);
    end
    checks++;
    assert (state === e.st) else begin
      errors++;
      $error("FAIL %s state observed=%0d expected=%0d", e.tag, state, e.st);
    end
  endtask

  initial begin
    int koff [9];
    koff = '{47, 37, 27, 17, 7, 2, 1, 0, 0};

    // Reset; rst is dropped just after an edge that still saw it high.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    assert (speed === 7'd0) else begin
      errors++;
      $error("FAIL reset_speed observed=%0d expected=0", speed);
    end
    chk_state("reset_state", 2'(ST_OFF));
    chk_bit("reset_ovs", overspeed, 1'b0);
    chk_bit("reset_lug", lugging, 1'b0);

    // g1 accel: first tick lands exactly TICK_DIV cycles after reset.
    key_on = 1'b1; gear = 3'd1; accel = 1'b1;
    repeat (TICK_DIV - 1) @(posedge clk);
    #1 chk_state("pre_first_tick", 2'(ST_OFF));
    @(posedge clk);
    #1 chk_state("first_tick_idle", 2'(ST_IDLE));
    tick_exp(0, 2'(ST_DRIVE), "idle_to_drive");
    for (int t = 3; t <= 30; t++)
      tick_exp((t - 2 < 25) ? t - 2 : 25, 2'(ST_DRIVE), "g1_accel");
    chk_bit("g1_sat_ovs", overspeed, 1'b0);

    // Full-range ramp to 80, then downshift to g2 with no pedals.
    gear = 3'd6;
    for (int s = 26; s <= 80; s++) tick_exp(s, 2'(ST_DRIVE), "g6_accel");
    gear = 3'd2; accel = 1'b0;
    #1 chk_bit("downshift_ovs", overspeed, 1'b1);
    for (int s = 79; s >= 45; s--) begin
      tick_exp(s, 2'(ST_DRIVE), "overspeed_bleed");
      chk_bit("bleed_ovs", overspeed, s > 45);
    end

    // g3 brake floor and coast floor at 35.
    gear = 3'd6; brake = 1'b1;
    for (int s = 44; s >= 40; s--) tick_exp(s, 2'(ST_DRIVE), "g6_brake");
    gear = 3'd3;
    for (int k = 1; k <= 7; k++)
      tick_exp((40 - k > 35) ? 40 - k : 35, 2'(ST_DRIVE), "g3_brake_floor");
    brake = 1'b0;
    for (int k = 0; k < 10; k++) tick_exp(35, 2'(ST_DRIVE), "g3_coast_floor");

    // Lugging in g4 at 20 until stall, then neutral to IDLE.
    gear = 3'd6; brake = 1'b1;
    for (int s = 34; s >= 20; s--) tick_exp(s, 2'(ST_DRIVE), "g6_brake_to20");
    gear = 3'd4; brake = 1'b0;
    #1 chk_bit("lug_start", lugging, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      tick_exp(20, 2'(ST_DRIVE), "lugging");
      chk_bit("lug_hold", lugging, 1'b1);
    end
    tick_exp(20, 2'(ST_STALL), "stall_entry");
    chk_bit("stall_lug", lugging, 1'b0);
    gear = 3'd0;
    tick_exp(20, 2'(ST_IDLE), "stall_to_idle");

    // Key-off stepped braking from 57.
    gear = 3'd6; accel = 1'b1;
    tick_exp(20, 2'(ST_DRIVE), "idle_to_drive2");
    for (int s = 21; s <= 57; s++) tick_exp(s, 2'(ST_DRIVE), "g6_accel57");
    key_on = 1'b0; brake = 1'b1; accel = 1'b0;
    foreach (koff[i]) tick_exp(koff[i], 2'(ST_OFF), "keyoff_step");

    // brake+accel in g6 at 50, then mid-run reset.
    key_on = 1'b1; brake = 1'b0; accel = 1'b1;
    tick_exp(0, 2'(ST_IDLE), "off_to_idle");
    tick_exp(0, 2'(ST_DRIVE), "idle_to_drive3");
    for (int s = 1; s <= 50; s++) tick_exp(s, 2'(ST_DRIVE), "g6_accel50");
    brake = 1'b1;
    tick_exp(49, 2'(ST_DRIVE), "brake_wins");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    assert (speed === 7'd0) else begin
      errors++;
      $error("FAIL midrst_speed observed=%0d expected=0", speed);
    end
    chk_state("midrst_state", 2'(ST_OFF));
    rst = 1'b0; brake = 1'b0; accel = 1'b0;
    repeat (TICK_DIV - 1) @(posedge clk);
    #1 chk_state("midrst_phase_pre", 2'(ST_OFF));
    @(posedge clk);
    #1 chk_state("midrst_phase_tick", 2'(ST_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/speed_governor.md
# speed_governor

Parametrised vehicle speed governor: integrates accelerate/brake requests into a saturating speed register. Speed limits depend on the selected gear, and the block adds coasting decay, downshift over-speed handling, stall detection and key-off stepped braking. It sits between the pedal/gear input conditioning and the speed display/BCD path, and is driven by a shared update tick rather than every clock.

## Interface
- SPEED_W, 7, speed register width; must hold MAX_SPEED
- MAX_SPEED, 99, absolute speed ceiling
- TICK_DIV, 4, clock cycles per update tick (≥1)
- COAST_DIV, 8, ticks per coast decrement (≥1)
- STALL_TICKS, 16, consecutive lugging ticks before stall (≥1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- key_on  in  1  ignition
- accel  in  1  accelerate request
- brake  in  1  brake request; has priority over accel
- gear  in  3  0 = neutral, 1–5 = forward gears, 6 = full-range mode, 7 = neutral
- speed  out  SPEED_W  current speed
- state  out  2  OFF=0, IDLE=1, DRIVE=2, STALL=3
- overspeed  out  1  speed > gear max
- lugging  out  1  speed < gear min in DRIVE

## Operation
- Gear bands [min,max]:
  - g1: 0–25
  - g2: 15–45
  - g3: 35–65
  - g4: 55–85
  - g5: 75–MAX_SPEED
  - g6: 0–MAX_SPEED
  - neutral: 0–MAX_SPEED
- All speed and state updates occur only on tick cycles. Between ticks, all registers hold.
- States:
  - OFF: entered from any state when key_on=0. On each tick with brake=1, speed decreases by a stepped amount: speed>10 gives −10, speed>5 gives −5, speed>0 gives −1. With brake=0, speed holds. accel is ignored.
  - IDLE: key_on=1 and neutral gear. brake gives −1 per tick, floor 0. accel is ignored. Otherwise speed coasts down by −1 every COAST_DIV ticks, floor 0. A non-neutral gear moves the block to DRIVE.
  - DRIVE: key_on=1 and gear 1–6. Rules in priority order:
    1. speed > gear max: −1 per tick regardless of inputs.
    2. brake: −1, floor = gear min.
    3. accel: +1, ceiling = gear max.
    4. Otherwise coast: −1 every COAST_DIV ticks, floor = gear min.
  - DRIVE, lugging: speed < gear min. In this condition brake is still allowed down to 0, and accel +1 still applies. A lug counter increments on each tick with lugging=1 and accel=0, and clears otherwise. When the counter reaches STALL_TICKS, the block enters STALL.
  - Neutral gear in DRIVE moves the block to IDLE.
  - STALL: speed coasts to 0 (−1 every COAST_DIV ticks; brake gives −1 per tick). accel is ignored. Exit to IDLE when gear becomes neutral. key_on=0 moves the block to OFF.
  - OFF→IDLE on the first tick with key_on=1, regardless of gear.
- Coast counter clears on any tick where accel or brake is active, and on any state change.
- Arithmetic never wraps. Decrement results below floor clamp to floor; increments clamp to min(gear max, MAX_SPEED).
- overspeed/lugging are combinational from the registered speed, state and current gear.

## Timing
- Reset values: speed=0, state=OFF, overspeed=0, lugging=0. Prescaler, coast and lug counters are 0.
- Tick asserts on the cycle where prescaler count = TICK_DIV−1. First tick occurs TICK_DIV cycles after rst deasserts.
- Inputs are sampled on the tick cycle. speed/state are visible one cycle later (registered).
- Simultaneous brake+accel: brake wins.
- Gear change and key_on drop on the same tick: OFF wins.
- rst mid-operation: all registers return to reset values on the next edge, prescaler phase included.

## Structure
- Package speed_governor_pkg holds:
  - state enum
  - gear min/max constant arrays indexed by gear[2:0]
  - key-off step thresholds (10/5) and step sizes (10/5/1)
- Sub-module tick_prescaler (parameter DIV) generates the single-cycle tick pulse, cleared by rst.

## Test plan
All scenarios use TICK_DIV=4, COAST_DIV=8, STALL_TICKS=16.
- Reset then key_on=1, gear=1, accel held 30 ticks → OFF→IDLE→DRIVE; speed saturates at 25, overspeed=0.
- Reach 80 in g5, shift to g2, no inputs → overspeed=1; speed falls 80→45 in 35 ticks, then overspeed=0.
- g3 at 40, hold brake → speed falls to 35 and holds. Release brake, no accel → holds at 35 (coast floor).
- g4 with speed 20, no accel 16 ticks → lugging=1 throughout, state=STALL after 16th tick. Set gear=0 → IDLE.
- key_on=0 at speed 57 with brake held → 47, 37, 27, 17, 7, 2, 1, 0 on successive ticks; state=OFF.
- brake+accel together in g6 at 50 → 49 next tick. Assert rst mid-run → speed=0, state=OFF one cycle later.
